// File: rtl/fifo_pkg.sv
// Shared types and helpers for the ring-buffer FIFO.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fifo_pkg;

    // FIFO_FWFT: head word is shown combinationally and rden consumes it.
    // FIFO_REG:  rden fetches the head word into an output register (1-cycle latency).
    typedef enum logic {
        FIFO_FWFT = 1'b0,
        FIFO_REG  = 1'b1
    } fifo_mode_e;

    // Pointer width: storage index bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH simple dual-port register file for the ring FIFO.
// Latency: write lands on the clock edge; read port is asynchronous (0 cycles).
// Backpressure: none; the parent decides when a write is allowed.
//
// Ports:
//   clk      : write clock
//   i_we     : write enable
//   i_waddr  : write index
//   i_wdata  : write data
//   i_raddr  : read index
//   o_rdata  : read data, combinational from i_raddr
module fifo_mem #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       i_we,
    input  logic [$clog2(DEPTH)-1:0]   i_waddr,
    input  logic [DATA_WIDTH-1:0]      i_wdata,
    input  logic [$clog2(DEPTH)-1:0]   i_raddr,
    output logic [DATA_WIDTH-1:0]      o_rdata
);

    // Storage is deliberately left unreset: occupancy tracking in the parent
    // guarantees no entry is read before it has been written.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_ring.sv
// Single-clock circular-buffer FIFO with occupancy, threshold flags and sticky errors.
// Latency: write visible next cycle; FWFT read 0 cycles, REG read 1 cycle.
// Backpressure: writes refused when full unless a read frees a slot in the same
//   cycle; reads refused when empty; refusals set sticky overflow/underflow.
//
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   wren / i_data               : write request and data
//   rden                        : read request
//   clr_err                     : synchronous clear of overflow/underflow
//   o_data / o_valid            : read data and its qualifier
//   count                       : occupancy 0..DEPTH
//   full, empty                 : count==DEPTH, count==0
//   almost_full, almost_empty   : count>=AFULL_THRESH, count<=AEMPTY_THRESH
//   overflow, underflow         : sticky refusal flags
module fifo_ring
    import fifo_pkg::*;
#(
    parameter int         DEPTH         = 8,
    parameter int         DATA_WIDTH    = 8,
    parameter fifo_mode_e MODE          = FIFO_FWFT,
    parameter int         AFULL_THRESH  = DEPTH - 1,
    parameter int         AEMPTY_THRESH = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wren,
    input  logic                         rden,
    input  logic [DATA_WIDTH-1:0]        i_data,
    input  logic                         clr_err,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic                         o_valid,
    output logic [ptr_w(DEPTH)-1:0]      count,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] AF_T    = PW'(AFULL_THRESH);
    localparam logic [PW-1:0] AE_T    = PW'(AEMPTY_THRESH);
    localparam logic [PW-1:0] ONE     = PW'(1);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_ring: DEPTH must be a power of two >= 2");
    end
    if (AFULL_THRESH < 0 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("fifo_ring: AFULL_THRESH must be within 0..DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH) begin : g_bad_aempty
        $error("fifo_ring: AEMPTY_THRESH must be within 0..DEPTH");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          r_rd_ptr;
    logic [PW-1:0]          r_count;
    logic                   r_overflow;
    logic                   r_underflow;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_rd_ok;
    logic                   w_wr_ok;
    logic [DATA_WIDTH-1:0]  w_rd_data;

    // Status is decoded purely from the registered count, so wren/rden never
    // reach an output combinationally.
    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == '0);

    // A read frees a slot in the same cycle, so a full FIFO still accepts a
    // write alongside a read. The reverse is not true: an empty FIFO has no
    // write-to-read bypass, so a simultaneous read is refused.
    assign w_rd_ok = rden && !w_empty;
    assign w_wr_ok = wren && (!w_full || w_rd_ok);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    fifo_mem #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_ok),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (i_data),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rd_data)
    );

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Natural binary increment: the low bits wrap DEPTH-1 -> 0 and
            // carry into the MSB, which acts as the lap indicator.
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + ONE;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + ONE;
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + ONE;
                2'b01:   r_count <= r_count - ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags: a new refusal in the clr_err cycle keeps the flag set.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (r_overflow  && !clr_err) || (wren && !w_wr_ok);
            r_underflow <= (r_underflow && !clr_err) || (rden && !w_rd_ok);
        end
    end

    // ------------------------------------------------------------------
    // Read data path
    // ------------------------------------------------------------------
    if (MODE == FIFO_REG) begin : g_reg
        logic [DATA_WIDTH-1:0] r_data;
        logic                  r_valid;

        // o_valid is a one-cycle pulse per accepted read; o_data holds the
        // last fetched word between reads.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_valid <= w_rd_ok;
                if (w_rd_ok) begin
                    r_data <= w_rd_data;
                end
            end
        end

        assign o_data  = r_data;
        assign o_valid = r_valid;
    end else begin : g_fwft
        // Head of queue is always on the output; rden acknowledges it.
        assign o_data  = w_rd_data;
        assign o_valid = !w_empty;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign count        = r_count;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= AF_T);
    assign almost_empty = (r_count <= AE_T);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_ring.sv
// Self-checking bench for fifo_ring: one FWFT and one REG instance, DEPTH=4.
// Latency: n/a.
// Backpressure: n/a.
module tb_fifo_ring;
    import fifo_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // FWFT instance signals
    logic       f_rst_n, f_wren, f_rden, f_clr;
    logic [7:0] f_din, f_dout;
    logic       f_vld, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [2:0] f_cnt;

    // REG instance signals
    logic       r_rst_n, r_wren, r_rden, r_clr;
    logic [7:0] r_din, r_dout;
    logic       r_vld, r_full, r_empty, r_af, r_ae, r_ovf, r_udf;
    logic [2:0] r_cnt;

    fifo_ring #(.DEPTH(4), .DATA_WIDTH(8), .MODE(FIFO_FWFT)) dut_fwft (
        .clk(clk), .rst_n(f_rst_n), .wren(f_wren), .rden(f_rden), .i_data(f_din),
        .clr_err(f_clr), .o_data(f_dout), .o_valid(f_vld), .count(f_cnt),
        .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
        .overflow(f_ovf), .underflow(f_udf)
    );

    fifo_ring #(.DEPTH(4), .DATA_WIDTH(8), .MODE(FIFO_REG)) dut_reg (
        .clk(clk), .rst_n(r_rst_n), .wren(r_wren), .rden(r_rden), .i_data(r_din),
        .clr_err(r_clr), .o_data(r_dout), .o_valid(r_vld), .count(r_cnt),
        .full(r_full), .empty(r_empty), .almost_full(r_af), .almost_empty(r_ae),
        .overflow(r_ovf), .underflow(r_udf)
    );

    int n_chk = 0;
    int n_err = 0;

    // Scoreboard plus reference flags for whichever instance is being exercised.
    logic [7:0] q[$];
    bit         m_ovf, m_udf;
    logic [7:0] m_last;
    int         max_cnt;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_last  = 8'h00;
        max_cnt = 0;
    endtask

    // Reference behaviour of one clock edge, evaluated on pre-edge occupancy.
    task automatic model_edge(input bit wr, input bit rd, input bit clr,
                              input logic [7:0] d, output bit rd_ok);
        bit wr_ok;
        rd_ok = rd && (q.size() > 0);
        wr_ok = wr && ((q.size() < 4) || rd_ok);
        m_ovf = (m_ovf && !clr) || (wr && !wr_ok);
        m_udf = (m_udf && !clr) || (rd && !rd_ok);
        if (rd_ok) m_last = q.pop_front();
        if (wr_ok) q.push_back(d);
        if (q.size() > max_cnt) max_cnt = q.size();
    endtask

    task automatic fw_status(input string ph);
        check({ph, "_cnt"},   32'(f_cnt),   32'(q.size()));
        check({ph, "_full"},  32'(f_full),  32'(q.size() == 4));
        check({ph, "_empty"}, 32'(f_empty), 32'(q.size() == 0));
        check({ph, "_af"},    32'(f_af),    32'(q.size() >= 3));
        check({ph, "_ae"},    32'(f_ae),    32'(q.size() <= 1));
        check({ph, "_ovf"},   32'(f_ovf),   32'(m_ovf));
        check({ph, "_udf"},   32'(f_udf),   32'(m_udf));
        check({ph, "_vld"},   32'(f_vld),   32'(q.size() > 0));
    endtask

    task automatic reg_status(input string ph);
        check({ph, "_cnt"},   32'(r_cnt),   32'(q.size()));
        check({ph, "_full"},  32'(r_full),  32'(q.size() == 4));
        check({ph, "_empty"}, 32'(r_empty), 32'(q.size() == 0));
        check({ph, "_af"},    32'(r_af),    32'(q.size() >= 3));
        check({ph, "_ae"},    32'(r_ae),    32'(q.size() <= 1));
        check({ph, "_ovf"},   32'(r_ovf),   32'(m_ovf));
        check({ph, "_udf"},   32'(r_udf),   32'(m_udf));
    endtask

    // FWFT: the head word is compared before the edge that consumes it.
    task automatic fw_step(input string ph, input bit wr, input bit rd, input bit clr,
                           input logic [7:0] d);
        bit rd_ok;
        @(negedge clk);
        if (rd && q.size() > 0) check({ph, "_data"}, 32'(f_dout), 32'(q[0]));
        f_wren = wr; f_rden = rd; f_clr = clr; f_din = d;
        @(posedge clk);
        model_edge(wr, rd, clr, d, rd_ok);
        #1;
        f_wren = 1'b0; f_rden = 1'b0; f_clr = 1'b0;
        fw_status(ph);
    endtask

    // REG: the fetched word and its one-cycle valid appear after the edge.
    task automatic reg_step(input string ph, input bit wr, input bit rd, input bit clr,
                            input logic [7:0] d);
        bit rd_ok;
        @(negedge clk);
        r_wren = wr; r_rden = rd; r_clr = clr; r_din = d;
        @(posedge clk);
        model_edge(wr, rd, clr, d, rd_ok);
        #1;
        r_wren = 1'b0; r_rden = 1'b0; r_clr = 1'b0;
        check({ph, "_vld"},  32'(r_vld),  32'(rd_ok));
        check({ph, "_data"}, 32'(r_dout), 32'(m_last));
        reg_status(ph);
    endtask

    initial begin
        f_rst_n = 1'b0; f_wren = 1'b0; f_rden = 1'b0; f_clr = 1'b0; f_din = 8'h00;
        r_rst_n = 1'b0; r_wren = 1'b0; r_rden = 1'b0; r_clr = 1'b0; r_din = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        fw_status("rst_f");
        reg_status("rst_r");
        check("rst_r_vld",  32'(r_vld),  32'd0);
        check("rst_r_data", 32'(r_dout), 32'd0);
        @(negedge clk);
        f_rst_n = 1'b1;
        r_rst_n = 1'b1;

        // ---------------- FWFT: fill, overflow, clear ----------------
        fw_step("fill", 1, 0, 0, 8'h11);
        fw_step("fill", 1, 0, 0, 8'h22);
        fw_step("fill", 1, 0, 0, 8'h33);
        fw_step("fill", 1, 0, 0, 8'h44);
        fw_step("ovf",  1, 0, 0, 8'h55);
        fw_step("clr",  0, 0, 1, 8'h00);

        // Full with simultaneous write and read: 0x11 leaves, 0x66 joins the tail.
        fw_step("fullrw", 1, 1, 0, 8'h66);
        for (int i = 0; i < 4; i++) fw_step("drain", 0, 1, 0, 8'h00);

        // Empty with simultaneous write and read: read refused, write kept.
        fw_step("emptyrw", 1, 1, 0, 8'h77);
        fw_step("rd77",    0, 1, 0, 8'h00);
        fw_step("clr2",    0, 0, 1, 8'h00);

        // Wrap the pointers several laps with single-entry traffic.
        max_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            fw_step("wrap", 1, 0, 0, 8'(i));
            fw_step("wrap", 0, 1, 0, 8'h00);
        end
        check("wrap_maxcnt", 32'(max_cnt), 32'd1);

        // ---------------- REG mode ----------------
        model_reset();
        reg_step("reg_wr",   1, 0, 0, 8'hA5);
        reg_step("reg_rd",   0, 1, 0, 8'h00);
        reg_step("reg_hold", 0, 0, 0, 8'h00);
        reg_step("reg_udf",  0, 1, 0, 8'h00);
        reg_step("reg_clr",  0, 0, 1, 8'h00);

        // Mid-burst asynchronous reset while o_valid is high.
        reg_step("burst", 1, 0, 0, 8'h01);
        reg_step("burst", 1, 0, 0, 8'h02);
        reg_step("burst", 1, 0, 0, 8'h03);
        reg_step("burst", 0, 1, 0, 8'h00);
        #2;
        r_rst_n = 1'b0;
        #1;
        check("arst_cnt",   32'(r_cnt),   32'd0);
        check("arst_empty", 32'(r_empty), 32'd1);
        check("arst_full",  32'(r_full),  32'd0);
        check("arst_vld",   32'(r_vld),   32'd0);
        check("arst_data",  32'(r_dout),  32'd0);
        model_reset();
        @(negedge clk);
        r_rst_n = 1'b1;
        reg_step("post", 1, 0, 0, 8'h5A);
        reg_step("post", 0, 1, 0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
